// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types for the SIC memory-lock path: store-port widths, the lock FSM
// state encoding and the requester-index width helper.
package mem_lock_arbiter_pkg;

    localparam int SIC_ADDR_W = 30;
    localparam int SIC_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } mem_lock_state_t;

    // A single requester still needs a 1-bit owner field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_lock_arbiter_age_select.sv
// Oldest-first selector: picks the requester whose issue id is closest to
// head_id going forward (modulo 2^ID_WIDTH); lowest index wins ties.
module age_select #(
    parameter int NUM_SIC  = 2,
    parameter int ID_WIDTH = 4,
    parameter int IDX_W    = 1
) (
    input  logic [NUM_SIC-1:0]               req,
    input  logic [NUM_SIC-1:0][ID_WIDTH-1:0] issue_id,
    input  logic [ID_WIDTH-1:0]              head_id,
    output logic                             any_req,
    output logic [IDX_W-1:0]                 sel_idx
);

    logic [ID_WIDTH-1:0] age_v;
    logic [ID_WIDTH-1:0] best_age;
    logic                found;

    always_comb begin
        age_v    = '0;
        best_age = '0;
        found    = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            // Unsigned wrap of the subtraction is the whole age calculation.
            age_v = issue_id[i] - head_id;
            if (req[i] && (!found || (age_v < best_age))) begin
                found    = 1'b1;
                best_age = age_v;
                sel_idx  = IDX_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mem_lock_arbiter.sv
// Memory lock arbiter: grants the oldest requesting SIC, muxes its store port
// to memory, and forces release after MAX_HOLD grant cycles.
module mem_lock_arbiter
    import mem_lock_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = 2,
    parameter int ID_WIDTH = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SIC-1:0]                   req,
    input  logic [NUM_SIC-1:0]                   release_lock,
    input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]     req_issue_id,
    input  logic [ID_WIDTH-1:0]                  head_id,
    input  logic [NUM_SIC-1:0][SIC_ADDR_W-1:0]   sic_addr,
    input  logic [NUM_SIC-1:0][SIC_DATA_W-1:0]   sic_wdata,
    input  logic [NUM_SIC-1:0]                   sic_wen,
    output logic [NUM_SIC-1:0]                   mem_grant,
    output logic [SIC_ADDR_W-1:0]                mem_addr,
    output logic [SIC_DATA_W-1:0]                mem_wdata,
    output logic                                 mem_wen,
    output logic [idx_width(NUM_SIC)-1:0]        owner,
    output logic                                 busy,
    output logic                                 timeout_err,
    output logic [31:0]                          grant_count
);

    localparam int OWNER_W = idx_width(NUM_SIC);
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);

    mem_lock_state_t     state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [31:0]         grant_count_q, grant_count_d;
    logic                timeout_err_q, timeout_err_d;

    logic                any_req;
    logic [OWNER_W-1:0]  sel_idx;
    logic [HOLD_W-1:0]   hold_inc;
    logic                owner_done;

    age_select #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_WIDTH),
        .IDX_W    (OWNER_W)
    ) u_age_select (
        .req      (req),
        .issue_id (req_issue_id),
        .head_id  (head_id),
        .any_req  (any_req),
        .sel_idx  (sel_idx)
    );

    assign hold_inc   = HOLD_W'(hold_cnt_q + 1'b1);
    // A dropped request ends the lock exactly like an explicit release.
    assign owner_done = release_lock[owner_q] || !req[owner_q];

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        hold_cnt_d    = hold_cnt_q;
        grant_count_d = grant_count_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = GRANT;
                    owner_d       = sel_idx;
                    hold_cnt_d    = '0;
                    grant_count_d = grant_count_q + 32'd1;
                end
            end
            GRANT: begin
                hold_cnt_d = hold_inc;
                if (owner_done) begin
                    state_d = IDLE;
                end else if (hold_inc == HOLD_W'(MAX_HOLD)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            hold_cnt_q    <= '0;
            grant_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_count_q <= grant_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q == GRANT);
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;
    assign grant_count = grant_count_q;

    always_comb begin
        mem_grant = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            mem_grant[i] = busy && (owner_q == OWNER_W'(i));
        end
    end

    assign mem_addr  = busy ? sic_addr[owner_q]  : '0;
    assign mem_wdata = busy ? sic_wdata[owner_q] : '0;
    assign mem_wen   = busy && sic_wen[owner_q];

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Scoreboard bench for mem_lock_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of the lock rules.
`timescale 1ns/1ps
module tb_mem_lock_arbiter;

    localparam int NS = 2;
    localparam int IW = 4;
    localparam int MH = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NS-1:0]         req, release_lock, sic_wen;
    logic [NS-1:0][IW-1:0] req_issue_id;
    logic [IW-1:0]         head_id;
    logic [NS-1:0][29:0]   sic_addr;
    logic [NS-1:0][31:0]   sic_wdata;
    logic [NS-1:0]         mem_grant;
    logic [29:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_wen;
    logic [0:0]            owner;
    logic                  busy, timeout_err;
    logic [31:0]           grant_count;

    mem_lock_arbiter #(.NUM_SIC(NS), .ID_WIDTH(IW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .release_lock(release_lock),
        .req_issue_id(req_issue_id), .head_id(head_id), .sic_addr(sic_addr),
        .sic_wdata(sic_wdata), .sic_wen(sic_wen), .mem_grant(mem_grant),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .owner(owner), .busy(busy), .timeout_err(timeout_err),
        .grant_count(grant_count)
    );

    typedef struct {
        logic [1:0]  grant;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        own;
        logic        bsy;
        logic        terr;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: lock held or not, holder, grant cycles so far.
    bit          m_valid = 1'b0;
    bit          m_busy;
    int          m_owner;
    int          m_cycles;
    logic [31:0] m_count;
    bit          m_terr;

    // Staged stimulus, applied just after each rising edge.
    logic                  s_rst;
    logic [NS-1:0]         s_req, s_rel, s_wen;
    logic [NS-1:0][IW-1:0] s_ids;
    logic [IW-1:0]         s_head;
    logic [NS-1:0][29:0]   s_addr;
    logic [NS-1:0][31:0]   s_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_and_advance();
        exp_t e;
        int best, best_age, a;
        if (m_valid) begin
            e.bsy   = m_busy;
            e.own   = 1'(m_owner);
            e.grant = m_busy ? 2'(1 << m_owner) : 2'b00;
            e.addr  = m_busy ? sic_addr[m_owner] : 30'd0;
            e.wdata = m_busy ? sic_wdata[m_owner] : 32'd0;
            e.wen   = m_busy && sic_wen[m_owner];
            e.terr  = m_terr;
            e.cnt   = m_count;
            exp_q.push_back(e);
        end
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_owner = 0; m_cycles = 0;
            m_count = 32'd0; m_terr = 1'b0;
        end else if (m_valid) begin
            if (!m_busy) begin
                m_terr = 1'b0;
                best = -1; best_age = 1 << IW;
                for (int i = 0; i < NS; i++) begin
                    a = (int'(req_issue_id[i]) - int'(head_id) + (1 << IW)) % (1 << IW);
                    if (req[i] && a < best_age) begin
                        best = i; best_age = a;
                    end
                end
                if (best >= 0) begin
                    m_busy = 1'b1; m_owner = best; m_cycles = 1; m_count = m_count + 1;
                end
            end else if (release_lock[m_owner] || !req[m_owner]) begin
                m_busy = 1'b0; m_terr = 1'b0;
            end else if (m_cycles == MH) begin
                m_busy = 1'b0; m_terr = 1'b1;
            end else begin
                m_cycles++; m_terr = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("mem_grant",   32'(mem_grant),   32'(mon_e.grant));
            chk("mem_addr",    32'(mem_addr),    32'(mon_e.addr));
            chk("mem_wdata",   mem_wdata,        mon_e.wdata);
            chk("mem_wen",     32'(mem_wen),     32'(mon_e.wen));
            chk("owner",       32'(owner),       32'(mon_e.own));
            chk("busy",        32'(busy),        32'(mon_e.bsy));
            chk("timeout_err", 32'(timeout_err), 32'(mon_e.terr));
            chk("grant_count", grant_count,      mon_e.cnt);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
        rst = s_rst; req = s_req; release_lock = s_rel; sic_wen = s_wen;
        req_issue_id = s_ids; head_id = s_head; sic_addr = s_addr; sic_wdata = s_wdata;
        push_and_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        s_rst = 1'b1; s_req = '0; s_rel = '0; s_wen = '0;
        cyc();
        s_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; release_lock = '0; sic_wen = '0;
        req_issue_id = '0; head_id = '0; sic_addr = '0; sic_wdata = '0;
        s_rst = 1'b1; s_req = 2'b11; s_rel = '0; s_wen = '0;
        s_ids = '0; s_head = '0; s_addr = '0; s_wdata = '0;

        // Reset with both requesting
        cyc(); cyc();
        chk("rst_grant", 32'(mem_grant), 32'd0);
        chk("rst_count", grant_count, 32'd0);
        s_rst = 1'b0;
        cyc();
        chk("rst_idle_after", 32'(mem_grant), 32'd0);
        cyc();
        chk("rst_first_grant", 32'(mem_grant), 32'b01);
        s_rel = 2'b01; cyc();
        s_rel = 2'b00; s_req = 2'b00; cyc();
        chk("rst_released", 32'(mem_grant), 32'd0);

        // Oldest-first then gap then the other requester
        do_reset();
        s_head = 4'd3; s_ids[0] = 4'd5; s_ids[1] = 4'd4; s_req = 2'b11;
        cyc(); cyc();
        chk("oldest_grant", 32'(mem_grant), 32'b10);
        s_rel = 2'b10; cyc();
        s_rel = 2'b00; s_req = 2'b01; cyc();
        chk("oldest_gap", 32'(mem_grant), 32'd0);
        cyc();
        chk("oldest_second", 32'(mem_grant), 32'b01);
        chk("oldest_count", grant_count, 32'd2);
        s_req = 2'b00; cyc(); cyc();

        // Wrap-around age
        do_reset();
        s_head = 4'd14; s_ids[0] = 4'd1; s_ids[1] = 4'd15; s_req = 2'b11;
        cyc(); cyc();
        chk("wrap_grant", 32'(mem_grant), 32'b10);
        s_req = 2'b00; cyc(); cyc();

        // Tie and store mux
        do_reset();
        s_head = 4'd0; s_ids[0] = 4'd7; s_ids[1] = 4'd7; s_req = 2'b11;
        s_wen = 2'b11; s_addr[0] = 30'h10; s_wdata[0] = 32'hDEADBEEF;
        s_addr[1] = 30'h55; s_wdata[1] = 32'h12345678;
        cyc();
        chk("tie_idle_wen", 32'(mem_wen), 32'd0);
        chk("tie_idle_addr", 32'(mem_addr), 32'd0);
        cyc();
        chk("tie_grant", 32'(mem_grant), 32'b01);
        chk("tie_wen", 32'(mem_wen), 32'd1);
        chk("tie_addr", 32'(mem_addr), 32'h10);
        chk("tie_wdata", mem_wdata, 32'hDEADBEEF);
        s_rel = 2'b01; cyc();
        s_rel = 2'b00; s_req = 2'b00; cyc();
        chk("tie_after_wen", 32'(mem_wen), 32'd0);
        chk("tie_after_wdata", mem_wdata, 32'd0);
        s_wen = 2'b00;

        // Abort: owner drops req
        do_reset();
        s_req = 2'b01; cyc(); cyc();
        chk("abort_grant", 32'(mem_grant), 32'b01);
        s_req = 2'b00; cyc(); cyc();
        chk("abort_drop", 32'(mem_grant), 32'd0);
        chk("abort_terr", 32'(timeout_err), 32'd0);

        // Timeout after MAX_HOLD grant cycles
        do_reset();
        s_req = 2'b01; cyc();
        for (int k = 0; k < MH; k++) begin
            cyc();
            chk("hold_grant", 32'(mem_grant), 32'b01);
        end
        cyc();
        chk("to_grant", 32'(mem_grant), 32'd0);
        chk("to_terr", 32'(timeout_err), 32'd1);
        cyc();
        chk("to_terr_once", 32'(timeout_err), 32'd0);
        s_req = 2'b00; cyc(); cyc();

        // Release in the last allowed cycle beats the timeout
        do_reset();
        s_req = 2'b01; cyc();
        for (int k = 0; k < MH - 1; k++) cyc();
        s_rel = 2'b01; cyc();
        chk("rel15_grant", 32'(mem_grant), 32'b01);
        s_rel = 2'b00; s_req = 2'b00; cyc();
        chk("rel15_terr", 32'(timeout_err), 32'd0);
        chk("rel15_drop", 32'(mem_grant), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            s_rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 7) == 0) s_req[i] = ~s_req[i];
                s_rel[i] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) s_ids[i] = 4'($urandom);
                s_addr[i]  = 30'($urandom);
                s_wdata[i] = $urandom;
                s_wen[i]   = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0) s_head = 4'($urandom);
            cyc();
        end

        s_rst = 1'b0; s_req = '0; s_rel = '0;
        cyc();
        @(posedge clk);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
